// File: rtl/priority_grant_stage.sv
// rtl/priority_grant_stage.sv - sticky request capture with registered lowest-bit-first grant slot
// Optional GRANT_STAGE_MASK_EN adds a mask input that excludes requestors from selection.
module priority_grant_stage #(
    parameter int WORD_WIDTH = 0,
    // An unset width falls back to a single requestor so the ranges stay legal
    localparam int W = (WORD_WIDTH < 1) ? 1 : WORD_WIDTH
) (
    input  logic         clock,
    input  logic         clear,
    input  logic [W-1:0] request,
`ifdef GRANT_STAGE_MASK_EN
    input  logic [W-1:0] mask,
`endif
    output logic [W-1:0] pending,
    output logic [W-1:0] grant,
    output logic         grant_valid,
    input  logic         grant_ready
);

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    slot_state_t  state_q, state_d;
    logic [W-1:0] pending_q, pending_d;
    logic [W-1:0] grant_q, grant_d;
    logic [W-1:0] cand;
    logic [W-1:0] sel;
    logic [W-1:0] retired;
    logic         loadable;

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q   <= SLOT_EMPTY;
            pending_q <= '0;
            grant_q   <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            grant_q   <= grant_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        retired  = '0;
`ifdef GRANT_STAGE_MASK_EN
        cand     = pending_q & ~mask;
`else
        cand     = pending_q;
`endif
        // Two's-complement isolate of the lowest set bit; bit 0 wins
        sel      = cand & (~cand + {{(W-1){1'b0}}, 1'b1});
        loadable = (state_q == SLOT_EMPTY) || grant_ready;

        if (loadable) begin
            grant_d = sel;
            retired = sel;
            state_d = (cand != '0) ? SLOT_FULL : SLOT_EMPTY;
        end

        // A new request on the bit being retired re-pends it
        pending_d = (pending_q & ~retired) | request;
    end

    assign pending     = pending_q;
    assign grant       = grant_q;
    assign grant_valid = (state_q == SLOT_FULL);

endmodule

// File: tb/tb_priority_grant_stage.sv
// tb/tb_priority_grant_stage.sv - directed vector bench for priority_grant_stage (WORD_WIDTH=8)
// Mask sequence expectations follow GRANT_STAGE_MASK_EN when it is defined.
module tb_priority_grant_stage;

    logic       clock;
    logic       clear;
    logic [7:0] request;
    logic [7:0] mask;
    logic [7:0] pending;
    logic [7:0] grant;
    logic       grant_valid;
    logic       grant_ready;

    int errors = 0;
    int checks = 0;

    priority_grant_stage #(.WORD_WIDTH(8)) dut (
        .clock       (clock),
        .clear       (clear),
        .request     (request),
`ifdef GRANT_STAGE_MASK_EN
        .mask        (mask),
`endif
        .pending     (pending),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_ready (grant_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       clr;
        logic [7:0] req;
        logic       rdy;
        logic [7:0] exp_pending;
        logic [7:0] exp_grant;
        logic       exp_valid;
    } vec_t;

    localparam int NVEC = 31;
    vec_t vecs[NVEC];

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic clr, input logic [7:0] req, input logic rdy, input logic [7:0] msk);
        @(negedge clock);
        clear       = clr;
        request     = req;
        grant_ready = rdy;
        mask        = msk;
        @(posedge clock);
        #1;
    endtask

    task automatic expect3(input string tag, input logic [7:0] ep, input logic [7:0] eg, input logic ev);
        check8({tag, " pending"}, pending, ep);
        check8({tag, " grant"}, grant, eg);
        check8({tag, " grant_valid"}, {7'd0, grant_valid}, {7'd0, ev});
        check8({tag, " onehot"}, {7'd0, $onehot0(grant)}, 8'd1);
    endtask

    initial begin
        clear = 1'b1; request = '0; grant_ready = 1'b0; mask = '0;

        // reset with all-ones requests
        vecs[0]  = '{1'b1, 8'hFF, 1'b0, 8'h00, 8'h00, 1'b0};
        vecs[1]  = '{1'b1, 8'hFF, 1'b1, 8'h00, 8'h00, 1'b0};
        // ordering A4 -> 04, 20, 80
        vecs[2]  = '{1'b0, 8'hA4, 1'b1, 8'hA4, 8'h00, 1'b0};
        vecs[3]  = '{1'b0, 8'h00, 1'b1, 8'hA0, 8'h04, 1'b1};
        vecs[4]  = '{1'b0, 8'h00, 1'b1, 8'h80, 8'h20, 1'b1};
        vecs[5]  = '{1'b0, 8'h00, 1'b1, 8'h00, 8'h80, 1'b1};
        vecs[6]  = '{1'b0, 8'h00, 1'b1, 8'h00, 8'h00, 1'b0};
        // back-pressure: hold 01 with pending 06 for five cycles
        vecs[7]  = '{1'b0, 8'h07, 1'b1, 8'h07, 8'h00, 1'b0};
        vecs[8]  = '{1'b0, 8'h00, 1'b0, 8'h06, 8'h01, 1'b1};
        vecs[9]  = '{1'b0, 8'h00, 1'b0, 8'h06, 8'h01, 1'b1};
        vecs[10] = '{1'b0, 8'h00, 1'b0, 8'h06, 8'h01, 1'b1};
        vecs[11] = '{1'b0, 8'h00, 1'b0, 8'h06, 8'h01, 1'b1};
        vecs[12] = '{1'b0, 8'h00, 1'b0, 8'h06, 8'h01, 1'b1};
        vecs[13] = '{1'b0, 8'h00, 1'b0, 8'h06, 8'h01, 1'b1};
        vecs[14] = '{1'b0, 8'h00, 1'b1, 8'h04, 8'h02, 1'b1};
        vecs[15] = '{1'b0, 8'h00, 1'b1, 8'h00, 8'h04, 1'b1};
        vecs[16] = '{1'b0, 8'h00, 1'b1, 8'h00, 8'h00, 1'b0};
        // re-request on the edge bit 0 is granted
        vecs[17] = '{1'b0, 8'h01, 1'b1, 8'h01, 8'h00, 1'b0};
        vecs[18] = '{1'b0, 8'h01, 1'b1, 8'h01, 8'h01, 1'b1};
        vecs[19] = '{1'b0, 8'h00, 1'b1, 8'h00, 8'h01, 1'b1};
        vecs[20] = '{1'b0, 8'h00, 1'b1, 8'h00, 8'h00, 1'b0};
        // no pre-emption by a higher-priority arrival
        vecs[21] = '{1'b0, 8'h80, 1'b0, 8'h80, 8'h00, 1'b0};
        vecs[22] = '{1'b0, 8'h00, 1'b0, 8'h00, 8'h80, 1'b1};
        vecs[23] = '{1'b0, 8'h01, 1'b0, 8'h01, 8'h80, 1'b1};
        vecs[24] = '{1'b0, 8'h00, 1'b0, 8'h01, 8'h80, 1'b1};
        vecs[25] = '{1'b0, 8'h00, 1'b1, 8'h00, 8'h01, 1'b1};
        vecs[26] = '{1'b0, 8'h00, 1'b1, 8'h00, 8'h00, 1'b0};
        // mid-operation clear discards state and concurrent requests
        vecs[27] = '{1'b0, 8'hF1, 1'b0, 8'hF1, 8'h00, 1'b0};
        vecs[28] = '{1'b0, 8'h00, 1'b0, 8'hF0, 8'h01, 1'b1};
        vecs[29] = '{1'b1, 8'h0F, 1'b0, 8'h00, 8'h00, 1'b0};
        vecs[30] = '{1'b0, 8'h00, 1'b1, 8'h00, 8'h00, 1'b0};

        for (int i = 0; i < NVEC; i++) begin
            step(vecs[i].clr, vecs[i].req, vecs[i].rdy, 8'h00);
            expect3($sformatf("vec%0d", i), vecs[i].exp_pending, vecs[i].exp_grant, vecs[i].exp_valid);
        end

        // mask sequence: pending 03, mask bit 0, then drop the mask
        step(1'b0, 8'h03, 1'b0, 8'h01);
        expect3("mask0", 8'h03, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0, 8'h01);
`ifdef GRANT_STAGE_MASK_EN
        expect3("mask1", 8'h01, 8'h02, 1'b1);
        step(1'b0, 8'h00, 1'b1, 8'h00);
        expect3("mask2", 8'h00, 8'h01, 1'b1);
`else
        expect3("mask1", 8'h02, 8'h01, 1'b1);
        step(1'b0, 8'h00, 1'b1, 8'h00);
        expect3("mask2", 8'h00, 8'h02, 1'b1);
`endif
        step(1'b0, 8'h00, 1'b1, 8'h00);
        expect3("mask3", 8'h00, 8'h00, 1'b0);

`ifdef GRANT_STAGE_MASK_EN
        // a fully masked pending bit waits, then is served once unmasked
        step(1'b0, 8'h04, 1'b1, 8'h04);
        expect3("mhold0", 8'h04, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b1, 8'h04);
        expect3("mhold1", 8'h04, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0, 8'h00);
        expect3("mhold2", 8'h00, 8'h04, 1'b1);
        // masking the held bit does not revoke it
        step(1'b0, 8'h00, 1'b0, 8'h04);
        expect3("mhold3", 8'h00, 8'h04, 1'b1);
        step(1'b0, 8'h00, 1'b1, 8'h04);
        expect3("mhold4", 8'h00, 8'h00, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
